// File: rtl/assign_sweep.sv
// assign_sweep: enumerates candidate values over valid/ready and collects verdicts.
// Optional verdict timeout: define SWEEP_TIMEOUT_EN.
module assign_sweep #(
   parameter int VAR_W       = 10,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [VAR_W-1:0] start_val,
   input  logic [VAR_W:0]   sweep_len,
   output logic             cand_valid,
   input  logic             cand_ready,
   output logic [VAR_W-1:0] cand_data,
   input  logic             res_valid,
   input  logic             res_sat,
   output logic             res_ready,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             exhausted,
   output logic [VAR_W-1:0] sat_value,
   output logic [VAR_W:0]   tried,
   output logic             timeout_err
);

   localparam int LW = VAR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   state_t           state, state_n;
   logic [VAR_W-1:0] cand_n, sat_n;
   logic [VAR_W:0]   tried_n, len_q, len_n, tried_inc;
   logic             done_n, found_n, exh_n;

`ifdef SWEEP_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [CW-1:0] wcnt, wcnt_n;
   logic          to_q, to_n;
   assign timeout_err = to_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign tried_inc  = tried + LW'(1);
   assign cand_valid = (state == ISSUE);
   assign res_ready  = (state == WAIT);
   assign busy       = (state == ISSUE) || (state == WAIT);

   // Next-state and next-register values for the sweep controller
   always_comb begin
      state_n = state;
      cand_n  = cand_data;
      sat_n   = sat_value;
      tried_n = tried;
      len_n   = len_q;
      done_n  = 1'b0;
      found_n = found;
      exh_n   = exhausted;
`ifdef SWEEP_TIMEOUT_EN
      wcnt_n  = wcnt;
      to_n    = to_q;
`endif
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               len_n   = sweep_len;
               cand_n  = start_val;
               sat_n   = '0;
               tried_n = '0;
               found_n = 1'b0;
               exh_n   = 1'b0;
`ifdef SWEEP_TIMEOUT_EN
               to_n    = 1'b0;
`endif
               if (sweep_len == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  exh_n   = 1'b1;
               end else begin
                  state_n = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (cand_ready) begin
               state_n = WAIT;
`ifdef SWEEP_TIMEOUT_EN
               wcnt_n  = '0;
`endif
            end
         end
         WAIT: begin
            if (res_valid) begin
               tried_n = tried_inc;
               if (res_sat) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  found_n = 1'b1;
                  sat_n   = cand_data;
               end else if (tried_inc == len_q) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  exh_n   = 1'b1;
               end else begin
                  state_n = ISSUE;
                  cand_n  = cand_data + VAR_W'(1);
               end
            end
`ifdef SWEEP_TIMEOUT_EN
            else if (wcnt + CW'(1) == CW'(TIMEOUT_CYC)) begin
               state_n = DONE;
               done_n  = 1'b1;
               to_n    = 1'b1;
            end else begin
               wcnt_n = wcnt + CW'(1);
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand_data <= '0;
         sat_value <= '0;
         tried     <= '0;
         len_q     <= '0;
         done      <= 1'b0;
         found     <= 1'b0;
         exhausted <= 1'b0;
      end else begin
         state     <= state_n;
         cand_data <= cand_n;
         sat_value <= sat_n;
         tried     <= tried_n;
         len_q     <= len_n;
         done      <= done_n;
         found     <= found_n;
         exhausted <= exh_n;
      end
   end

`ifdef SWEEP_TIMEOUT_EN
   // WAIT-cycle counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
         to_q <= 1'b0;
      end else begin
         wcnt <= wcnt_n;
         to_q <= to_n;
      end
   end
`endif

endmodule

// File: tb/tb_assign_sweep.sv
// tb_assign_sweep: directed tests for assign_sweep with VAR_W=4.
// Inputs change on the falling edge; outputs are observed there too.
module tb_assign_sweep;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] start_val;
   logic [4:0] sweep_len;
   logic       cand_valid;
   logic       cand_ready;
   logic [3:0] cand_data;
   logic       res_valid;
   logic       res_sat;
   logic       res_ready;
   logic       busy;
   logic       done;
   logic       found;
   logic       exhausted;
   logic [3:0] sat_value;
   logic [4:0] tried;
   logic       timeout_err;

   int tests_run = 0;
   int fails = 0;
   logic [3:0] cand_q[$];

   always #5 clk = ~clk;

   assign_sweep #(.VAR_W(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .start(start), .start_val(start_val), .sweep_len(sweep_len),
      .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
      .res_valid(res_valid), .res_sat(res_sat), .res_ready(res_ready),
      .busy(busy), .done(done), .found(found), .exhausted(exhausted),
      .sat_value(sat_value), .tried(tried), .timeout_err(timeout_err)
   );

   // Evaluator model: ready always, verdict in the first WAIT cycle when respond=1.
   // sat_t is the satisfying value, or -1 for none. Cycle 1 = first cycle after the start edge.
   task automatic run_sweep(input logic [3:0] sv, input logic [4:0] len,
                            input int sat_t, input bit respond, input int budget,
                            output int done_cyc, output int done_cnt);
      cand_q.delete();
      done_cyc = -1;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1; start_val = sv; sweep_len = len;
      cand_ready = 1'b1; res_valid = 1'b0; res_sat = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (cand_valid) cand_q.push_back(cand_data);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
         res_valid = respond && res_ready;
         res_sat = respond && res_ready && (sat_t == int'(cand_data));
         @(negedge clk);
      end
      res_valid = 1'b0;
      res_sat = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0; start_val = '0; sweep_len = '0;
      cand_ready = 1'b0; res_valid = 1'b0; res_sat = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({cand_valid, res_ready, busy, done, found, exhausted, timeout_err,
           cand_data, sat_value, tried} !== 20'd0) begin
         fails++;
         $display("FAIL reset_outputs got %h %h %h %b%b%b%b%b%b%b want all 0",
                  cand_data, sat_value, tried, cand_valid, res_ready, busy,
                  done, found, exhausted, timeout_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_found();
      int dc, dn;
      logic [3:0] exp[3];
      exp = '{4'd3, 4'd4, 4'd5};
      run_sweep(4'd3, 5'd5, 5, 1'b1, 40, dc, dn);
      tests_run++;
      if (cand_q.size() != 3) begin
         fails++;
         $display("FAIL found_count got %0d want 3", cand_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (cand_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL found_cand%0d got %0d want %0d", i, cand_q[i], exp[i]);
            end
         end
      end
      tests_run++;
      if (dc != 7 || dn != 1) begin
         fails++;
         $display("FAIL found_done got cyc=%0d pulses=%0d want cyc=7 pulses=1", dc, dn);
      end
      tests_run++;
      if ({found, exhausted, sat_value, tried, busy} !== {1'b1, 1'b0, 4'd5, 5'd3, 1'b0}) begin
         fails++;
         $display("FAIL found_result got f=%b e=%b sv=%0d t=%0d b=%b want 1 0 5 3 0",
                  found, exhausted, sat_value, tried, busy);
      end
   endtask

   task automatic test_exhaust_wrap();
      int dc, dn;
      logic [3:0] exp[4];
      exp = '{4'd14, 4'd15, 4'd0, 4'd1};
      run_sweep(4'd14, 5'd4, -1, 1'b1, 40, dc, dn);
      tests_run++;
      if (cand_q.size() != 4) begin
         fails++;
         $display("FAIL exh_count got %0d want 4", cand_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cand_q[i] !== exp[i]) begin
               fails++;
               $display("FAIL exh_cand%0d got %0d want %0d", i, cand_q[i], exp[i]);
            end
         end
      end
      tests_run++;
      if ({found, exhausted, tried, dn} !== {1'b1 ^ 1'b1, 1'b1, 5'd4, 32'd1}) begin
         fails++;
         $display("FAIL exh_result got f=%b e=%b t=%0d pulses=%0d want 0 1 4 1",
                  found, exhausted, tried, dn);
      end
   endtask

   task automatic test_zero_len();
      int dc, dn;
      run_sweep(4'd7, 5'd0, -1, 1'b1, 10, dc, dn);
      tests_run++;
      if (dc != 1 || dn != 1 || cand_q.size() != 0) begin
         fails++;
         $display("FAIL zero_len got cyc=%0d pulses=%0d cands=%0d want 1 1 0",
                  dc, dn, cand_q.size());
      end
      tests_run++;
      if ({exhausted, found, tried, busy} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
         fails++;
         $display("FAIL zero_len_flags got e=%b f=%b t=%0d b=%b want 1 0 0 0",
                  exhausted, found, tried, busy);
      end
   endtask

   task automatic test_full_sweep();
      int dc, dn;
      bit ok;
      run_sweep(4'd5, 5'd16, -1, 1'b1, 60, dc, dn);
      ok = (cand_q.size() == 16);
      for (int i = 0; i < 16 && ok; i++)
         if (cand_q[i] !== 4'(5 + i)) ok = 1'b0;
      tests_run++;
      if (!ok) begin
         fails++;
         $display("FAIL full_cands got %0d candidates want 16 from 5 upward", cand_q.size());
      end
      tests_run++;
      if ({exhausted, tried, dc} !== {1'b1, 5'd16, 32'd33}) begin
         fails++;
         $display("FAIL full_result got e=%b t=%0d cyc=%0d want 1 16 33", exhausted, tried, dc);
      end
   endtask

   task automatic test_stall();
      @(negedge clk);
      start = 1'b1; start_val = 4'd9; sweep_len = 5'd3; cand_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tests_run++;
         if ({cand_valid, cand_data, tried, busy, res_ready} !== {1'b1, 4'd9, 5'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL stall_hold%0d got v=%b d=%0d t=%0d b=%b rr=%b want 1 9 0 1 0",
                     i, cand_valid, cand_data, tried, busy, res_ready);
         end
         start = (i == 2 || i == 3);
         start_val = 4'd2; sweep_len = 5'd1;
         res_valid = (i == 3 || i == 4);
         res_sat = res_valid;
         if (i < 6) @(negedge clk);
      end
      start = 1'b0; res_valid = 1'b0; res_sat = 1'b0; cand_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({res_ready, cand_valid} !== 2'b10) begin
         fails++;
         $display("FAIL stall_wait got rr=%b v=%b want 1 0", res_ready, cand_valid);
      end
      res_valid = 1'b1; res_sat = 1'b1;
      @(negedge clk);
      res_valid = 1'b0; res_sat = 1'b0;
      tests_run++;
      if ({done, found, sat_value, tried} !== {1'b1, 1'b1, 4'd9, 5'd1}) begin
         fails++;
         $display("FAIL stall_result got d=%b f=%b sv=%0d t=%0d want 1 1 9 1",
                  done, found, sat_value, tried);
      end
   endtask

   task automatic test_reset_mid();
      int dc, dn;
      @(negedge clk);
      start = 1'b1; start_val = 4'd6; sweep_len = 5'd5; cand_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      res_valid = 1'b0;
      @(negedge clk);
      res_valid = 1'b1; res_sat = 1'b0;
      @(negedge clk);
      res_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({res_ready, cand_data, tried} !== {1'b1, 4'd7, 5'd1}) begin
         fails++;
         $display("FAIL mid_setup got rr=%b d=%0d t=%0d want 1 7 1", res_ready, cand_data, tried);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({cand_valid, res_ready, busy, done, found, exhausted, timeout_err,
           cand_data, sat_value, tried} !== 20'd0) begin
         fails++;
         $display("FAIL mid_reset got d=%0d sv=%0d t=%0d v=%b rr=%b b=%b want all 0",
                  cand_data, sat_value, tried, cand_valid, res_ready, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_sweep(4'd11, 5'd2, 12, 1'b1, 20, dc, dn);
      tests_run++;
      if (cand_q.size() != 2 || cand_q[0] !== 4'd11 || cand_q[1] !== 4'd12 ||
          {found, sat_value, tried} !== {1'b1, 4'd12, 5'd2}) begin
         fails++;
         $display("FAIL mid_restart got n=%0d f=%b sv=%0d t=%0d want 2 1 12 2",
                  cand_q.size(), found, sat_value, tried);
      end
   endtask

   task automatic test_timeout();
      int dc, dn;
      run_sweep(4'd0, 5'd3, -1, 1'b0, 20, dc, dn);
`ifdef SWEEP_TIMEOUT_EN
      tests_run++;
      if (dc != 10 || dn != 1) begin
         fails++;
         $display("FAIL timeout_done got cyc=%0d pulses=%0d want 10 1", dc, dn);
      end
      tests_run++;
      if ({timeout_err, found, exhausted, busy} !== 4'b1000) begin
         fails++;
         $display("FAIL timeout_flags got to=%b f=%b e=%b b=%b want 1 0 0 0",
                  timeout_err, found, exhausted, busy);
      end
`else
      tests_run++;
      if ({dn != 0, busy, res_ready, timeout_err} !== 4'b0110) begin
         fails++;
         $display("FAIL no_timeout got pulses=%0d b=%b rr=%b to=%b want 0 1 1 0",
                  dn, busy, res_ready, timeout_err);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
   endtask

   initial begin
      test_reset();
      test_found();
      test_exhaust_wrap();
      test_zero_len();
      test_full_sweep();
      test_stall();
      test_reset_mid();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
